ex_mdu: RTL and testbench
=========================

# ex_mdu

Multiply/divide unit for the execute stage of the five-stage MIPS pipeline, directly downstream of the ID/EX pipeline register. It consumes the EX-stage instruction and the two forwarded register operands, and runs MULT/MULTU/DIV/DIVU as multi-cycle operations into private HI/LO registers. It services MFHI/MFLO/MTHI/MTLO. It also raises the stall request that the hazard unit uses to insert bubbles into ID/EX while the unit is busy.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- ins_e  in  32  instruction currently in EX (as output by ID/EX)
- rs_e  in  32  forwarded rs operand for the EX instruction
- rt_e  in  32  forwarded rt operand for the EX instruction
- ins_d  in  32  instruction currently in ID, for hazard detection
- start  out  1  combinational; EX instruction is MULT/MULTU/DIV/DIVU
- busy  out  1  registered; an operation is in flight
- md_stall  out  1  combinational; (start | busy) and ins_d is MDU-class
- md_out  out  32  combinational; HI if ins_e is MFHI, LO if MFLO, else 0
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Decode: opcode 6'h00 with funct: MFHI 10, MTHI 11, MFLO 12, MTLO 13, MULT 18, MULTU 19, DIV 1A, DIVU 1B (hex). MDU-class means any of these eight.
- start cycle:
  - Compute result from rs_e/rt_e into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Set busy.
- MULT: signed 64-bit product. MULTU: unsigned. HI = [63:32], LO = [31:0].
- DIV: signed. Quotient truncates toward zero into LO. Remainder takes the dividend's sign into HI. 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- DIVU: unsigned quotient into LO, remainder into HI.
- Divide by zero: operation still occupies DIV_CYCLES. HI/LO stay unchanged at completion.
- Counting: while busy, the counter decrements each edge. The edge on which the counter is 1 commits pending values into hi/lo, clears busy and sets the counter to 0.
- MTHI/MTLO: write rs_e into hi/lo at the edge ending the EX cycle, provided busy=0.
- Protocol violations: MTHI/MTLO, MFHI/MFLO or a new start while busy. md_stall prevents these.
  - If a violation occurs anyway, the MT write is dropped.
  - A new start is ignored.
  - MF returns the current, stale hi/lo.
- md_stall is asserted whenever ins_d is MDU-class and either start or busy is high. The hazard unit holds IF/ID and clears ID/EX.

## Timing
- Reset values: busy 0, counter 0, hi 0, lo 0, pending_hi 0, pending_lo 0. The combinational outputs follow from these.
- rst mid-operation: the in-flight result is discarded and all state returns to reset values on that edge. rst has priority over start and MT writes.
- Mult latency, with start high in cycle T:
  - busy is high in cycles T+1 .. T+MULT_CYCLES.
  - New hi/lo are visible from cycle T+MULT_CYCLES+1, the same cycle busy is 0.
- Div latency: identical, using DIV_CYCLES.
- An MDU instruction in ID during cycles T .. T+N is stalled. It reaches EX no earlier than cycle T+N+2 and sees committed values.
- md_out is valid in the same cycle as an MF instruction in EX. There is no internal bypass of the pending result.

## Structure
- The shared package mips_pkg holds the opcode/funct localparams (FUNCT_MFHI … FUNCT_DIVU, OP_SPECIAL) and the MDU op enum (MDU_NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO).
- One sub-module, mdu_decode: combinational, maps a 32-bit instruction to the op enum and an is_mdu flag. It is instantiated twice, once for ins_e and once for ins_d.
- The counter width is derived from max(MULT_CYCLES, DIV_CYCLES).

## Test plan
- MULT rs=0xFFFFFFFF, rt=2:
  - busy high for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU on the same operands gives hi=1, lo=0xFFFFFFFE.
- DIV rs=-7, rt=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFD after 10 cycles. DIVU rs=7, rt=0 → hi/lo unchanged, busy still high for 10 cycles.
- MULT followed by MFLO in ID:
  - md_stall is high in the start cycle and all 5 busy cycles, low afterwards.
  - The MFLO, once in EX, gives md_out equal to the new lo.
- MTHI rs=0x1234 with busy=0 → hi=0x1234 next cycle. MTLO issued while busy → lo is unaffected.
- rst asserted in the 3rd busy cycle of a DIV → busy=0, hi=lo=0 next cycle, and no late commit afterwards.
- Back-to-back MULT then DIV, with the DIV separated by the stall → each commits independently and hi/lo reflect the DIV result at its completion.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encodings and the multiply/divide op enum used across the execute stage.
package mips_pkg;

  localparam int unsigned INS_W   = 32;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] OP_SPECIAL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [3:0] {
    MDU_NONE,
    MULT,
    MULTU,
    DIV,
    DIVU,
    MTHI,
    MTLO,
    MFHI,
    MFLO
  } mdu_op_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_decode.sv
// Maps a 32-bit instruction to its multiply/divide op and an MDU-class flag.
import mips_pkg::*;

module mdu_decode (
  input  logic [INS_W-1:0] i_ins,
  output mdu_op_e          o_op,
  output logic             o_is_mdu
);

  // Register/shamt fields play no part in classifying the op.
  logic w_unused_fields;
  assign w_unused_fields = ^i_ins[25:6];

  always_comb begin
    o_op = MDU_NONE;
    if (i_ins[31:26] == OP_SPECIAL) begin
      case (i_ins[5:0])
        FUNCT_MFHI:  o_op = MFHI;
        FUNCT_MTHI:  o_op = MTHI;
        FUNCT_MFLO:  o_op = MFLO;
        FUNCT_MTLO:  o_op = MTLO;
        FUNCT_MULT:  o_op = MULT;
        FUNCT_MULTU: o_op = MULTU;
        FUNCT_DIV:   o_op = DIV;
        FUNCT_DIVU:  o_op = DIVU;
        default:     o_op = MDU_NONE;
      endcase
    end
  end

  assign o_is_mdu = (o_op != MDU_NONE);

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle MULT/DIV into private HI/LO,
// MF/MT servicing, and the stall request for MDU instructions waiting in ID.
import mips_pkg::*;

module ex_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INS_W-1:0] ins_e,
  input  logic [31:0]      rs_e,
  input  logic [31:0]      rt_e,
  input  logic [INS_W-1:0] ins_d,
  output logic             start,
  output logic             busy,
  output logic             md_stall,
  output logic [31:0]      md_out,
  output logic [31:0]      hi,
  output logic [31:0]      lo
);

  localparam int unsigned CNT_MAX = max_u(MULT_CYCLES, DIV_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  mdu_op_e          w_op_e;
  logic             w_unused_is_mdu_e;
  mdu_op_e          w_unused_op_d;
  logic             w_is_mdu_d;

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi, r_lo;
  logic [31:0]      r_pend_hi, r_pend_lo;
  logic             r_pend_ok;

  mdu_decode u_dec_e (.i_ins(ins_e), .o_op(w_op_e),        .o_is_mdu(w_unused_is_mdu_e));
  mdu_decode u_dec_d (.i_ins(ins_d), .o_op(w_unused_op_d), .o_is_mdu(w_is_mdu_d));

  logic w_is_mul, w_is_div;
  assign w_is_mul = (w_op_e == MULT) || (w_op_e == MULTU);
  assign w_is_div = (w_op_e == DIV)  || (w_op_e == DIVU);
  assign start    = w_is_mul || w_is_div;

  // Sign-extending for MULT lets one 64x64 multiply serve both signednesses.
  logic [63:0] w_mul_a, w_mul_b, w_prod;
  assign w_mul_a = (w_op_e == MULT) ? {{32{rs_e[31]}}, rs_e} : {32'b0, rs_e};
  assign w_mul_b = (w_op_e == MULT) ? {{32{rt_e[31]}}, rt_e} : {32'b0, rt_e};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow case.
  logic        w_a_neg, w_b_neg, w_div_zero;
  logic [31:0] w_a_mag, w_b_mag, w_b_safe, w_q_mag, w_r_mag, w_q, w_r;
  assign w_a_neg    = (w_op_e == DIV) && rs_e[31];
  assign w_b_neg    = (w_op_e == DIV) && rt_e[31];
  assign w_a_mag    = w_a_neg ? (~rs_e + 32'd1) : rs_e;
  assign w_b_mag    = w_b_neg ? (~rt_e + 32'd1) : rt_e;
  assign w_div_zero = (rt_e == 32'd0);
  assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag    = w_a_mag / w_b_safe;
  assign w_r_mag    = w_a_mag % w_b_safe;
  assign w_q        = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_ok <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
        if (r_pend_ok) begin
          r_hi <= r_pend_hi;
          r_lo <= r_pend_lo;
        end
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end else if (start) begin
      r_busy    <= 1'b1;
      r_cnt     <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      r_pend_hi <= w_is_mul ? w_prod[63:32] : w_r;
      r_pend_lo <= w_is_mul ? w_prod[31:0]  : w_q;
      r_pend_ok <= w_is_mul || !w_div_zero;
    end else if (w_op_e == MTHI) begin
      r_hi <= rs_e;
    end else if (w_op_e == MTLO) begin
      r_lo <= rs_e;
    end
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_stall = w_is_mdu_d && (start || r_busy);

  always_comb begin
    md_out = 32'd0;
    if (w_op_e == MFHI)      md_out = r_hi;
    else if (w_op_e == MFLO) md_out = r_lo;
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: directed scenarios plus randomized traffic against a cycle-level model.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins_e, rs_e, rt_e, ins_d;
  logic        start, busy, md_stall;
  logic [31:0] md_out, hi, lo;

  always #5 clk = ~clk;

  ex_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .ins_e(ins_e), .rs_e(rs_e), .rt_e(rt_e), .ins_d(ins_d),
    .start(start), .busy(busy), .md_stall(md_stall), .md_out(md_out), .hi(hi), .lo(lo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model: HI/LO, a pending result and cycles left until it lands.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_pok;
  int          m_left;

  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] fn(input logic [31:0] ins);
    return (ins[31:26] == 6'h00) ? ins[5:0] : 6'h3F;
  endfunction

  function automatic logic is_mdu(input logic [31:0] ins);
    return fn(ins) inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
  endfunction

  function automatic logic is_start(input logic [31:0] ins);
    return fn(ins) inside {6'h18, 6'h19, 6'h1A, 6'h1B};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] f);
    return {6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'h00, f};
  endfunction

  task automatic model_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    m_pok = 1'b1;
    case (f)
      6'h18: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5;
      end
      6'h19: begin
        p = 64'(a) * 64'(b);
        m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5;
      end
      6'h1A: begin
        m_left = 10;
        if (b == 32'd0) m_pok = 1'b0;
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          m_plo = 32'(q); m_phi = 32'(r);
        end
      end
      default: begin
        m_left = 10;
        if (b == 32'd0) m_pok = 1'b0;
        else begin m_plo = a / b; m_phi = a % b; end
      end
    endcase
  endtask

  // One clock cycle: drive, check every output against the model, advance the model.
  task automatic cyc(input logic r, input logic [31:0] ie, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] id);
    logic        e_start, e_busy, e_stall;
    logic [31:0] e_out;
    rst = r; ins_e = ie; rs_e = a; rt_e = b; ins_d = id;
    #2;
    e_start = is_start(ie);
    e_busy  = (m_left > 0);
    e_stall = is_mdu(id) && (e_start || e_busy);
    e_out   = (fn(ie) == 6'h10) ? m_hi : (fn(ie) == 6'h12) ? m_lo : 32'd0;
    check("start",    32'(start),    32'(e_start));
    check("busy",     32'(busy),     32'(e_busy));
    check("md_stall", 32'(md_stall), 32'(e_stall));
    check("md_out",   md_out,        e_out);
    check("hi",       hi,            m_hi);
    check("lo",       lo,            m_lo);
    if (r) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (e_start) begin
      model_start(fn(ie), a, b);
    end else if (fn(ie) == 6'h11) begin
      m_hi = a;
    end else if (fn(ie) == 6'h13) begin
      m_lo = a;
    end
    @(posedge clk);
    #1;
  endtask

  // Issue an op, then idle until busy drops (bounded); returns the busy cycle count.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] id, output int n);
    cyc(1'b0, mk(f), a, b, id);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      cyc(1'b0, NOP, 32'd0, 32'd0, id);
      n++;
    end
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [5:0] fl [8];
    fl = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return mk(fl[$urandom_range(0, 7)]);
      6:       return NOP;
      7:       return mk(6'h20);
      8:       return {6'h23, 20'($urandom), 6'h18};
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; ins_e = NOP; rs_e = 0; rt_e = 0; ins_d = NOP;
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0; m_left = 0;
    @(posedge clk);
    #1;
    check("rst_busy",   32'(busy),     32'd0);
    check("rst_hi",     hi,            32'd0);
    check("rst_lo",     lo,            32'd0);
    check("rst_start",  32'(start),    32'd0);
    check("rst_stall",  32'(md_stall), 32'd0);
    check("rst_md_out", md_out,        32'd0);
    cyc(1'b1, NOP, 0, 0, NOP);

    // MULT with MFLO waiting in ID, then the MFLO reaches EX.
    run_op(6'h18, 32'hFFFF_FFFF, 32'd2, mk(6'h12), n);
    check("mult_busy_len", 32'(n), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    cyc(1'b0, NOP, 0, 0, mk(6'h12));
    rst = 1'b0; ins_e = mk(6'h12); ins_d = NOP;
    #2;
    check("mflo_after_mult", md_out, 32'hFFFF_FFFE);
    cyc(1'b0, ins_e, 0, 0, NOP);

    run_op(6'h19, 32'hFFFF_FFFF, 32'd2, NOP, n);
    check("multu_hi", hi, 32'd1);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(6'h1A, 32'hFFFF_FFF9, 32'd2, NOP, n);
    check("div_busy_len", 32'(n), 32'd10);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    run_op(6'h1B, 32'd7, 32'd0, NOP, n);
    check("divu0_busy_len", 32'(n), 32'd10);
    check("divu0_hi", hi, 32'hFFFF_FFFF);
    check("divu0_lo", lo, 32'hFFFF_FFFD);

    run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, NOP, n);
    check("div_ovf_hi", hi, 32'd0);
    check("div_ovf_lo", lo, 32'h8000_0000);

    cyc(1'b0, mk(6'h11), 32'h1234, 0, NOP);
    check("mthi", hi, 32'h1234);

    // MTLO issued while busy must be dropped.
    cyc(1'b0, mk(6'h18), 32'd3, 32'd4, NOP);
    cyc(1'b0, mk(6'h13), 32'hDEAD, 0, NOP);
    n = 0;
    while (busy === 1'b1 && n < 40) begin cyc(1'b0, NOP, 0, 0, NOP); n++; end
    check("mtlo_busy_hi", hi, 32'd0);
    check("mtlo_busy_lo", lo, 32'd12);

    // MULT then a stalled DIV.
    run_op(6'h18, 32'd6, 32'd7, mk(6'h1A), n);
    check("b2b_mult_lo", lo, 32'd42);
    cyc(1'b0, NOP, 0, 0, mk(6'h1A));
    run_op(6'h1A, 32'd100, 32'd7, NOP, n);
    check("b2b_div_hi", hi, 32'd2);
    check("b2b_div_lo", lo, 32'd14);

    // Reset in the third busy cycle of a DIV discards the result.
    cyc(1'b0, mk(6'h1A), 32'h1000, 32'd3, NOP);
    cyc(1'b0, NOP, 0, 0, NOP);
    cyc(1'b0, NOP, 0, 0, NOP);
    cyc(1'b1, NOP, 0, 0, NOP);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    for (int i = 0; i < 15; i++) cyc(1'b0, NOP, 0, 0, NOP);
    check("no_late_hi", hi, 32'd0);
    check("no_late_lo", lo, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), rnd_ins(), rnd_opnd(), rnd_opnd(), rnd_ins());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
